// File: rtl/hls_run_pkg.sv
// Shared types for the HLS run sequencer: FSM states and result status codes.
package hls_run_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DUT_RST,
        S_LAUNCH,
        S_WAIT,
        S_REPORT
    } run_state_t;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_TIMEOUT = 2'd1;
    localparam logic [1:0] ST_ABORTED = 2'd2;

endpackage

// File: rtl/hls_result_fifo.sv
// Result FIFO; a push is accepted while full if a pop happens in the same cycle.
module hls_result_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    output logic         full,
    input  logic         pop,
    output logic         valid,
    output logic [W-1:0] rdata
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wp;
    logic [AW:0]  rp;
    logic         do_pop;
    logic         do_push;

    assign valid   = (wp != rp);
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign do_pop  = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rp[AW-1:0]];

    always_ff @(posedge clock) begin
        if (!reset) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wp[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/hls_run_sequencer.sv
// Sequences back-to-back runs of an HLS DUT and queues per-run cycle counts.
// Define HLS_RUN_TIMEOUT_EN to bound each run by TIMEOUT_CYCLES.
module hls_run_sequencer
    import hls_run_pkg::*;
#(
    parameter int CYCLE_W        = 32,
    parameter int RUN_W          = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int DUT_RST_CYCLES = 2,
    parameter int TIMEOUT_CYCLES = 200000000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [RUN_W-1:0]   cmd_runs,
    input  logic               abort,
    output logic               dut_reset,
    output logic               dut_start,
    input  logic               dut_done,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [CYCLE_W-1:0] res_cycles,
    output logic [RUN_W-1:0]   res_index,
    output logic [1:0]         res_status,
    output logic               busy
);

    localparam int RES_W = CYCLE_W + RUN_W + 2;
    localparam int RCW   = (DUT_RST_CYCLES > 1) ? $clog2(DUT_RST_CYCLES) : 1;
    localparam logic [RCW-1:0]     RST_LAST = RCW'(DUT_RST_CYCLES - 1);
    localparam logic [CYCLE_W-1:0] TMO      = CYCLE_W'(TIMEOUT_CYCLES);

    run_state_t         state, state_n;
    logic [RUN_W-1:0]   runs_left, runs_left_n;
    logic [RUN_W-1:0]   index, index_n;
    logic [CYCLE_W-1:0] counter, counter_n;
    logic [CYCLE_W-1:0] cnt_inc;
    logic [RCW-1:0]     rst_cnt, rst_cnt_n;
    logic [CYCLE_W-1:0] lat_cycles, lat_cycles_n;
    logic [1:0]         lat_status, lat_status_n;
    logic               abort_pend, abort_pend_n;
    logic               push;
    logic               abort_hit;
    logic               fifo_full;
    logic               fifo_valid;
    logic               fifo_space;
    logic               dut_reset_c;
    logic               dut_start_c;
    logic [RES_W-1:0]   fifo_rdata;

`ifndef HLS_RUN_TIMEOUT_EN
    logic unused_tmo;
    assign unused_tmo = ^TMO;
`endif

    assign cnt_inc    = (counter == '1) ? counter : counter + 1'b1;
    assign abort_hit  = abort && (state inside {S_DUT_RST, S_LAUNCH, S_WAIT});
    assign fifo_space = !fifo_full || res_ready;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state      <= S_IDLE;
            runs_left  <= '0;
            index      <= '0;
            counter    <= '0;
            rst_cnt    <= '0;
            lat_cycles <= '0;
            lat_status <= ST_OK;
            abort_pend <= 1'b0;
        end else begin
            state      <= state_n;
            runs_left  <= runs_left_n;
            index      <= index_n;
            counter    <= counter_n;
            rst_cnt    <= rst_cnt_n;
            lat_cycles <= lat_cycles_n;
            lat_status <= lat_status_n;
            abort_pend <= abort_pend_n;
        end
    end

    always_comb begin
        state_n      = state;
        runs_left_n  = runs_left;
        index_n      = index;
        counter_n    = counter;
        rst_cnt_n    = rst_cnt;
        lat_cycles_n = lat_cycles;
        lat_status_n = lat_status;
        abort_pend_n = abort_pend;
        push         = 1'b0;
        dut_reset_c  = 1'b1;
        dut_start_c  = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid && cmd_runs != '0) begin
                    runs_left_n = cmd_runs;
                    index_n     = '0;
                    counter_n   = '0;
                    rst_cnt_n   = '0;
                    state_n     = S_DUT_RST;
                end
            end
            S_DUT_RST: begin
                dut_reset_c = 1'b0;
                if (rst_cnt == RST_LAST) state_n = S_LAUNCH;
                else rst_cnt_n = rst_cnt + 1'b1;
            end
            S_LAUNCH: begin
                dut_start_c = 1'b1;
                counter_n   = CYCLE_W'(1);
                if (dut_done) begin
                    lat_cycles_n = CYCLE_W'(1);
                    lat_status_n = ST_OK;
                    state_n      = S_REPORT;
                end else begin
                    state_n = S_WAIT;
                end
            end
            S_WAIT: begin
                counter_n = cnt_inc;
                // the done cycle itself counts toward the run length
                if (dut_done) begin
                    lat_cycles_n = cnt_inc;
                    lat_status_n = ST_OK;
                    state_n      = S_REPORT;
                end
`ifdef HLS_RUN_TIMEOUT_EN
                else if (cnt_inc >= TMO) begin
                    lat_cycles_n = TMO;
                    lat_status_n = ST_TIMEOUT;
                    state_n      = S_REPORT;
                end
`endif
            end
            S_REPORT: begin
                if (abort) abort_pend_n = 1'b1;
                if (fifo_space) begin
                    push         = 1'b1;
                    index_n      = index + 1'b1;
                    runs_left_n  = runs_left - 1'b1;
                    abort_pend_n = 1'b0;
                    if (runs_left == RUN_W'(1) || abort_pend || abort) begin
                        state_n = S_IDLE;
                    end else begin
                        counter_n = '0;
                        rst_cnt_n = '0;
                        state_n   = S_DUT_RST;
                    end
                end
            end
            default: state_n = S_IDLE;
        endcase
        // a full FIFO defers the aborted result through REPORT
        if (abort_hit) begin
            dut_reset_c  = 1'b0;
            dut_start_c  = 1'b0;
            lat_cycles_n = counter;
            lat_status_n = ST_ABORTED;
            counter_n    = counter;
            if (fifo_space) begin
                push         = 1'b1;
                abort_pend_n = 1'b0;
                state_n      = S_IDLE;
            end else begin
                abort_pend_n = 1'b1;
                state_n      = S_REPORT;
            end
        end
    end

    hls_result_fifo #(
        .W     (RES_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .wdata ({lat_cycles_n, index, lat_status_n}),
        .full  (fifo_full),
        .pop   (res_valid && res_ready),
        .valid (fifo_valid),
        .rdata (fifo_rdata)
    );

    assign res_cycles = fifo_rdata[RES_W-1 -: CYCLE_W];
    assign res_index  = fifo_rdata[RUN_W+1 -: RUN_W];
    assign res_status = fifo_rdata[1:0];
    assign res_valid  = reset && fifo_valid;
    assign dut_reset  = reset && dut_reset_c;
    assign dut_start  = reset && dut_start_c;
    assign busy       = reset && (state != S_IDLE);
    assign cmd_ready  = reset && (state == S_IDLE);

endmodule

// File: tb/tb_hls_run_sequencer.sv
// Randomized scoreboard bench for hls_run_sequencer.
module tb_hls_run_sequencer;

    localparam int CW    = 32;
    localparam int RW    = 8;
    localparam int TMO_P = 50;

    logic          clock;
    logic          reset;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [RW-1:0] cmd_runs;
    logic          abort;
    logic          dut_reset;
    logic          dut_start;
    logic          dut_done;
    logic          res_valid;
    logic          res_ready;
    logic [CW-1:0] res_cycles;
    logic [RW-1:0] res_index;
    logic [1:0]    res_status;
    logic          busy;

    hls_run_sequencer #(
        .CYCLE_W        (CW),
        .RUN_W          (RW),
        .FIFO_DEPTH     (2),
        .DUT_RST_CYCLES (2),
        .TIMEOUT_CYCLES (TMO_P)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_runs   (cmd_runs),
        .abort      (abort),
        .dut_reset  (dut_reset),
        .dut_start  (dut_start),
        .dut_done   (dut_done),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_cycles (res_cycles),
        .res_index  (res_index),
        .res_status (res_status),
        .busy       (busy)
    );

    typedef struct {
        int cyc;
        int idx;
        int st;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   rdy_mode = 1;
    int   plan_kind[8];
    int   plan_val[8];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit hit, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // ready driver: 0 = hold low, 1 = hold high, 2 = random
    initial begin
        res_ready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (rdy_mode == 0) res_ready = 1'b0;
            else if (rdy_mode == 1) res_ready = 1'b1;
            else res_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (reset && res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_result: got cycles=%0d index=%0d status=%0d expected none",
                             res_cycles, res_index, res_status);
                end else begin
                    e = exp_q.pop_front();
                    check("res_cycles", 64'(res_cycles), 64'(e.cyc));
                    check("res_index", 64'(res_index), 64'(e.idx));
                    check("res_status", 64'(res_status), 64'(e.st));
                end
            end
        end
    end

    task automatic issue_cmd(input int n);
        @(posedge clock);
        #1;
        cmd_valid = 1'b1;
        cmd_runs  = RW'(n);
        @(negedge clock);
        check("cmd_ready", 64'(cmd_ready), 64'd1);
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_start(output bit ok, output int low);
        ok  = 1'b0;
        low = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clock);
            if (dut_start) begin
                ok = 1'b1;
                break;
            end
            if (!dut_reset) low++;
            else low = 0;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL start_timeout: got no dut_start expected one within 300 cycles");
        end
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clock);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        check("idle_reached", 64'(ok), 64'd1);
    endtask

    task automatic drain();
        for (int c = 0; c < 300; c++) begin
            @(negedge clock);
            if (exp_q.size() == 0) break;
        end
        check("queue_drained", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic pulse(input bit is_abort, input int k, input bit chk);
        if (k > 0) begin
            repeat (k) @(posedge clock);
            #1;
        end
        if (is_abort) abort = 1'b1;
        else dut_done = 1'b1;
        if (chk) begin
            @(negedge clock);
            check("abort_dut_reset", 64'(dut_reset), 64'd0);
        end
        @(posedge clock);
        #1;
        abort    = 1'b0;
        dut_done = 1'b0;
        if (chk) begin
            @(negedge clock);
            check("abort_next_idle", 64'(busy), 64'd0);
        end
    endtask

    // kind 0: done k cycles after start; 1: abort k cycles after start; 2: never done
    task automatic run_cmd(input int n, input bit wait_done, input bit chk_abort);
        bit   ok;
        int   low;
        exp_t e;
        issue_cmd(n);
        for (int i = 0; i < n; i++) begin
            wait_start(ok, low);
            if (!ok) return;
            check("dut_reset_low_cycles", 64'(low), 64'd2);
            e.idx = i;
            if (plan_kind[i] == 0) begin
                e.cyc = plan_val[i] + 1;
                e.st  = 0;
                exp_q.push_back(e);
                pulse(1'b0, plan_val[i], 1'b0);
            end else if (plan_kind[i] == 1) begin
                e.cyc = plan_val[i];
                e.st  = 2;
                exp_q.push_back(e);
                pulse(1'b1, plan_val[i], chk_abort);
                break;
            end else begin
`ifdef HLS_RUN_TIMEOUT_EN
                e.cyc = TMO_P;
                e.st  = 1;
                exp_q.push_back(e);
`endif
            end
        end
        if (wait_done) wait_idle();
    endtask

    initial begin
        bit ok;
        int low;
        int n;
        reset     = 1'b0;
        cmd_valid = 1'b0;
        cmd_runs  = '0;
        abort     = 1'b0;
        dut_done  = 1'b0;
        repeat (3) @(negedge clock);
        check("reset_outputs", 64'({res_valid, dut_start, dut_reset, busy, cmd_ready}), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        check("idle_cmd_ready", 64'(cmd_ready), 64'd1);
        check("idle_dut_reset", 64'(dut_reset), 64'd1);

        rdy_mode     = 1;
        plan_kind[0] = 0;
        plan_val[0]  = 10;
        run_cmd(1, 1'b1, 1'b0);

        plan_kind[0] = 0;
        plan_val[0]  = 0;
        plan_kind[1] = 0;
        plan_val[1]  = 0;
        run_cmd(2, 1'b1, 1'b0);

        rdy_mode = 0;
        for (int i = 0; i < 3; i++) begin
            plan_kind[i] = 0;
            plan_val[i]  = 3;
        end
        run_cmd(3, 1'b0, 1'b0);
        repeat (10) @(negedge clock);
        check("stall_busy", 64'(busy), 64'd1);
        check("stall_res_valid", 64'(res_valid), 64'd1);
        rdy_mode = 1;
        wait_idle();
        drain();

        plan_kind[0] = 1;
        plan_val[0]  = 7;
        plan_kind[1] = 0;
        plan_val[1]  = 2;
        run_cmd(2, 1'b1, 1'b1);
        drain();

        issue_cmd(0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            check("zero_runs_busy", 64'(busy), 64'd0);
        end

`ifdef HLS_RUN_TIMEOUT_EN
        plan_kind[0] = 2;
        plan_kind[1] = 2;
        run_cmd(2, 1'b1, 1'b0);
        drain();
`endif

        for (int t = 0; t < 12; t++) begin
            n        = int'($urandom_range(1, 4));
            rdy_mode = int'($urandom_range(1, 2));
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 5) == 0) begin
                    plan_kind[i] = 1;
                    plan_val[i]  = int'($urandom_range(1, 20));
                end else begin
                    plan_kind[i] = 0;
                    plan_val[i]  = int'($urandom_range(0, 30));
                end
            end
            run_cmd(n, 1'b1, 1'b0);
        end
        rdy_mode = 1;
        drain();

        issue_cmd(2);
        wait_start(ok, low);
        repeat (5) @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        check("midrun_reset_outputs",
              64'({res_valid, dut_start, dut_reset, busy, cmd_ready}), 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (20) @(negedge clock);
        check("midrun_reset_fifo_empty", 64'(res_valid), 64'd0);
        check("midrun_reset_busy", 64'(busy), 64'd0);
        check("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
